// File: rtl/mem_pkg.sv
// Shared types and constants for the memory arbiter and its attached memory.
//   state_e          : arbiter FSM state
//   owner_e          : which CPU port owns the outstanding read (also used as the round-robin winner)
//   MEM_ACCESS_DELAY : read latency of the attached memory, in cycles
package mem_pkg;

    typedef enum logic {
        IDLE      = 1'b0,
        READ_WAIT = 1'b1
    } state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_e;

    localparam int unsigned MEM_ACCESS_DELAY = 5;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   req[1:0]     : request vector, bit 0 = fetch port, bit 1 = data port
//   advance      : record this cycle's winner as last_winner
//   grant[1:0]   : one-hot grant, combinational from req and last_winner
module rr_arb2
    import mem_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    owner_e last_winner;

    // A tie goes to the port that did not win last time.
    always_comb begin
        grant = 2'b00;
        if (req == 2'b11) begin
            grant = (last_winner == OWN_D) ? 2'b01 : 2'b10;
        end else begin
            grant = req;
        end
    end

    // Reset to the data port so the fetch port wins the first tie.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_winner <= OWN_D;
        end else if (advance && (req != 2'b00)) begin
            last_winner <= grant[1] ? OWN_D : OWN_IF;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares a single-port memory between the instruction-fetch port and the
// load/store port: round-robin arbitration, one outstanding read, read data
// steered back to the issuing port, single-cycle writes, read watchdog.
//   clk_i, rst_i                : clock, asynchronous active-high reset
//   if_req/addr, if_gnt/rvalid/rdata            : fetch (read-only) port
//   d_req/we/addr/wdata, d_gnt/rvalid/rdata     : load/store port
//   mem_read_en/addr, mem_read_valid/data       : memory read port
//   mem_write_en/addr/data                      : memory write port
//   timeout_err_o               : sticky, a read was aborted by the watchdog
module mem_arbiter
    import mem_pkg::*;
#(
    parameter  int unsigned NUMWORDS  = 4096,
    parameter  int unsigned DATAWIDTH = 32,
    parameter  int unsigned TIMEOUT   = 16,
    localparam int unsigned ADDR_SIZE = $clog2(NUMWORDS)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,

    input  logic                 if_req_i,
    input  logic [ADDR_SIZE-1:0] if_addr_i,
    output logic                 if_gnt_o,
    output logic                 if_rvalid_o,
    output logic [DATAWIDTH-1:0] if_rdata_o,

    input  logic                 d_req_i,
    input  logic                 d_we_i,
    input  logic [ADDR_SIZE-1:0] d_addr_i,
    input  logic [DATAWIDTH-1:0] d_wdata_i,
    output logic                 d_gnt_o,
    output logic                 d_rvalid_o,
    output logic [DATAWIDTH-1:0] d_rdata_o,

    output logic                 mem_read_en_o,
    output logic [ADDR_SIZE-1:0] mem_read_addr_o,
    input  logic                 mem_read_valid_i,
    input  logic [DATAWIDTH-1:0] mem_read_data_i,
    output logic                 mem_write_en_o,
    output logic [ADDR_SIZE-1:0] mem_write_addr_o,
    output logic [DATAWIDTH-1:0] mem_write_data_o,

    output logic                 timeout_err_o
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    state_e               state;
    owner_e               owner;
    logic [ADDR_SIZE-1:0] rd_addr;
    logic [CNT_W-1:0]     wd_cnt;
    logic                 timeout_err;

    logic                 idle;
    logic [1:0]           arb_req;
    logic [1:0]           grant;
    logic                 win_if;
    logic                 win_d_rd;
    logic                 win_d_wr;
    logic                 rd_done;

    // Requests are only visible to the picker while idle and out of reset.
    assign idle    = (state == IDLE) && !rst_i;
    assign arb_req = idle ? {d_req_i, if_req_i} : 2'b00;

    rr_arb2 u_rr_arb2 (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .req     (arb_req),
        .advance (idle),
        .grant   (grant)
    );

    assign win_if   = grant[0];
    assign win_d_rd = grant[1] && !d_we_i;
    assign win_d_wr = grant[1] &&  d_we_i;
    assign rd_done  = (state == READ_WAIT) && mem_read_valid_i && !rst_i;

    // Grant, memory-port and response outputs.
    always_comb begin
        if_gnt_o         = grant[0];
        d_gnt_o          = grant[1];
        mem_read_en_o    = 1'b0;
        mem_read_addr_o  = '0;
        mem_write_en_o   = win_d_wr;
        mem_write_addr_o = win_d_wr ? d_addr_i  : '0;
        mem_write_data_o = win_d_wr ? d_wdata_i : '0;
        if_rvalid_o      = rd_done && (owner == OWN_IF);
        d_rvalid_o       = rd_done && (owner == OWN_D);
        if_rdata_o       = rst_i ? '0 : mem_read_data_i;
        d_rdata_o        = rst_i ? '0 : mem_read_data_i;
        timeout_err_o    = timeout_err;

        if (!rst_i) begin
            if (state == READ_WAIT) begin
                mem_read_en_o   = 1'b1;
                mem_read_addr_o = rd_addr;
            end else if (win_if) begin
                mem_read_en_o   = 1'b1;
                mem_read_addr_o = if_addr_i;
            end else if (win_d_rd) begin
                mem_read_en_o   = 1'b1;
                mem_read_addr_o = d_addr_i;
            end
        end
    end

    // FSM: a read grant parks the arbiter in READ_WAIT until valid or watchdog expiry.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= IDLE;
            owner       <= OWN_IF;
            rd_addr     <= '0;
            wd_cnt      <= '0;
            timeout_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_if || win_d_rd) begin
                        state   <= READ_WAIT;
                        owner   <= win_if ? OWN_IF : OWN_D;
                        rd_addr <= win_if ? if_addr_i : d_addr_i;
                        wd_cnt  <= '0;
                    end
                end
                READ_WAIT: begin
                    if (mem_read_valid_i) begin
                        state <= IDLE;
                    end else if (wd_cnt == CNT_W'(TIMEOUT - 1)) begin
                        state       <= IDLE;
                        timeout_err <= 1'b1;
                    end else begin
                        wd_cnt <= wd_cnt + CNT_W'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single-port `memory` block between the CPU instruction-fetch port and the load/store data port. It arbitrates round-robin between the two ports and allows one outstanding read at a time. It holds the memory read request until `read_valid` returns, then steers the read data back to the port that issued it. Writes complete in the grant cycle. A watchdog recovers from a read that never completes. The block sits between the CPU core and `memory`.

## Interface
- NUMWORDS, 4096, words in the attached memory; ADDR_SIZE = $clog2(NUMWORDS), derived
- DATAWIDTH, 32, word width
- TIMEOUT, 16, max cycles in READ_WAIT before abort; must be > memory access delay (5)
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- if_req_i  in  1  fetch read request
- if_addr_i  in  ADDR_SIZE  fetch word address
- if_gnt_o  out  1  fetch request accepted
- if_rvalid_o  out  1  fetch data valid, one-cycle pulse
- if_rdata_o  out  DATAWIDTH  fetch data
- d_req_i  in  1  data request
- d_we_i  in  1  1 = write, 0 = read
- d_addr_i  in  ADDR_SIZE  data word address
- d_wdata_i  in  DATAWIDTH  write data
- d_gnt_o  out  1  data request accepted
- d_rvalid_o  out  1  load data valid, one-cycle pulse
- d_rdata_o  out  DATAWIDTH  load data
- mem_read_en_o  out  1  to memory read_en_i
- mem_read_addr_o  out  ADDR_SIZE  to memory read_addr_i
- mem_read_valid_i  in  1  from memory read_valid_o
- mem_read_data_i  in  DATAWIDTH  from memory read_data_o
- mem_write_en_o, mem_write_addr_o, mem_write_data_o  out  1/ADDR_SIZE/DATAWIDTH  to memory write port
- timeout_err_o  out  1  sticky: a read was aborted by the watchdog

## Operation
- FSM states IDLE and READ_WAIT. Registers: state, owner (IF/D), latched read address, watchdog counter ($clog2(TIMEOUT+1) bits), last_winner, timeout_err.
- IDLE, no request: all outputs low.
- IDLE, one request: that port wins. Both requesting: the port that is not last_winner wins.
- Winner's gnt_o rises combinationally in the same cycle; last_winner updates on that edge.
- Winning read:
  - mem_read_en_o=1 with the winner's address in the grant cycle.
  - Latch owner and address, then go to READ_WAIT with counter=0.
- Winning write (d_we_i=1):
  - mem_write_en_o=1 with d_addr_i/d_wdata_i in the grant cycle.
  - Stay in IDLE; the next grant is possible the following cycle.
- READ_WAIT:
  - Both gnt_o low; request arrivals are ignored.
  - mem_read_en_o is held 1, with mem_read_addr_o held at the latched address.
  - On mem_read_valid_i: pulse the owner's rvalid_o and pass mem_read_data_i to its rdata_o combinationally, then go to IDLE.
  - Counter increments each cycle. On counter==TIMEOUT-1 with no valid: set timeout_err_o, go to IDLE, no rvalid.
- rdata_o of both ports always shows mem_read_data_i; only rvalid is steered.
- mem_read_valid_i seen in IDLE is ignored.
- Requester rules:
  - Hold req/addr/we/wdata stable until gnt.
  - Deassert or present a new request in the cycle after gnt.
- Reset (including mid-read):
  - State goes to IDLE; counter, last_winner (=D, so IF wins first tie) and timeout_err clear.
  - Every output is 0; an in-flight response is dropped.

## Timing
- Read: gnt at cycle 0; rvalid in the cycle mem_read_valid_i rises (cycle 5 with the 5-cycle memory); the next grant is possible at cycle 6.
- Write: gnt and mem_write_en at cycle 0; the next grant is possible at cycle 1.
- Both requesting continuously: grants alternate IF, D, IF, D; neither port waits more than one transaction of the other.
- No combinational path from mem_read_valid_i to any gnt_o.

## Structure
- Package `mem_pkg` holds:
  - typedef enum state_e {IDLE, READ_WAIT}
  - typedef enum owner_e {OWN_IF, OWN_D}
  - localparam MEM_ACCESS_DELAY = 5, shared with `memory`
- Sub-module `rr_arb2`: 2-way round-robin picker holding last_winner; inputs req[1:0] and advance, output one-hot grant.

## Test plan
- Reset then IF read at addr 0x010, memory returns 0xDEADBEEF after 5 cycles -> if_gnt at cycle 0, if_rvalid=1 with 0xDEADBEEF at cycle 5, d_rvalid stays 0.
- D write 0xA5A5A5A5 to 0x020, then D read of 0x020 next cycle -> mem_write_en pulse at cycle 0, read grant at cycle 1, d_rvalid with 0xA5A5A5A5 at cycle 6.
- IF and D both requesting reads for 4 transactions -> grant order IF, D, IF, D; each rvalid goes only to its owner.
- D write requested while an IF read is in READ_WAIT -> d_gnt held 0 until the cycle after if_rvalid.
- Memory never returns valid on a read (TIMEOUT=16) -> timeout_err_o=1 after 16 cycles, state IDLE, a following read completes normally.
- rst_i asserted at cycle 2 of a read -> all outputs 0 immediately; a late mem_read_valid_i produces no rvalid.
